// File: rtl/share_compress_2om.sv
// Registered 9->3 share compression stage with a 2-deep elastic valid/ready pipeline.
// Optional SHARE_REFRESH_EN re-masks the three output shares with fresh_m.
module share_compress_2om #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*WIDTH-1:0] in_shares,
  input  logic [2*WIDTH-1:0] fresh_m,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*WIDTH-1:0] out_shares,
  output logic [CNT_W-1:0]   item_cnt
);
  localparam int NIN  = 9;
  localparam int NOUT = 3;

  logic                        s1_valid_q, s1_valid_d;
  logic                        s2_valid_q, s2_valid_d;
  logic [NIN-1:0][WIDTH-1:0]   s1_q, s1_d;
  logic [NOUT-1:0][WIDTH-1:0]  s2_q, s2_d;
  logic [NOUT-1:0][WIDTH-1:0]  grp, s2_nxt;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        adv2, load1, fire;

  // Group XORs read only stage-1 flop outputs, so recombined values stay glitch-free.
  for (genvar k = 0; k < NOUT; k++) begin : g_grp
    assign grp[k] = s1_q[3*k] ^ s1_q[3*k+1] ^ s1_q[3*k+2];
  end

`ifdef SHARE_REFRESH_EN
  logic [1:0][WIDTH-1:0] m_q, m_d;

  always_comb begin
    m_d = m_q;
    if (load1)     m_d = fresh_m;
    else if (adv2) m_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) m_q <= '0;
    else     m_q <= m_d;
  end

  // m0 and m1 each appear in exactly two shares, so the unshared value is preserved.
  assign s2_nxt[0] = grp[0] ^ m_q[0];
  assign s2_nxt[1] = grp[1] ^ m_q[0] ^ m_q[1];
  assign s2_nxt[2] = grp[2] ^ m_q[1];
`else
  logic unused_fresh;
  assign unused_fresh = ^fresh_m;
  assign s2_nxt       = grp;
`endif

  always_comb begin
    adv2       = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready   = !s1_valid_q || adv2;
    load1      = in_valid && in_ready;
    fire       = s2_valid_q && out_ready;

    s1_valid_d = load1 ? 1'b1 : (adv2 ? 1'b0 : s1_valid_q);
    s2_valid_d = adv2  ? 1'b1 : (fire ? 1'b0 : s2_valid_q);

    // A stage that empties without reload is zeroed so stale shares never meet new ones.
    s1_d = s1_q;
    if (load1)     s1_d = in_shares;
    else if (adv2) s1_d = '0;

    s2_d = s2_q;
    if (adv2)      s2_d = s2_nxt;
    else if (fire) s2_d = '0;

    cnt_d = cnt_q + CNT_W'(fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_shares = s2_q;
  assign item_cnt   = cnt_q;
endmodule

// File: tb/tb_share_compress_2om.sv
// Directed bench for share_compress_2om: vector table plus stream, stall and reset sequences.
module tb_share_compress_2om;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [9*WIDTH-1:0] in_shares;
  logic [2*WIDTH-1:0] fresh_m;
  logic               out_valid;
  logic               out_ready;
  logic [3*WIDTH-1:0] out_shares;
  logic [CNT_W-1:0]   item_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [71:0] words [32];

  share_compress_2om #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_shares(in_shares), .fresh_m(fresh_m), .out_valid(out_valid),
    .out_ready(out_ready), .out_shares(out_shares), .item_cnt(item_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] sh;
    logic [15:0] fm;
    logic [23:0] exp_plain;
    logic [23:0] exp_ref;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xor9(input logic [71:0] s);
    logic [7:0] r = '0;
    for (int j = 0; j < 9; j++) r ^= s[j*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] xor3(input logic [23:0] s);
    return s[7:0] ^ s[15:8] ^ s[23:16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams words[0..n-1]; out_ready dropped for cycles [st0, st0+stlen).
  task automatic run_stream(input int n, input int st0, input int stlen,
                            output int first, output int last);
    int idx = 0, oidx = 0, cyc = 0, stall_run = 0;
    logic [23:0] held = '0;
    first = -1;
    last  = -1;
    while (oidx < n && cyc < 80) begin
      out_ready = !(cyc >= st0 && cyc < st0 + stlen);
      in_valid  = (idx < n);
      in_shares = (idx < n) ? words[idx] : '0;
      #1;
      if (out_valid && !out_ready) begin
        if (stall_run > 0)  chk("stall_hold", {8'h0, out_shares}, {8'h0, held});
        if (stall_run >= 2) chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
        held = out_shares;
        stall_run++;
      end else begin
        stall_run = 0;
      end
      if (out_valid && out_ready) begin
        chk("stream_xor", {24'h0, xor3(out_shares)}, {24'h0, xor9(words[oidx])});
        if (first < 0) first = cyc;
        last = cyc;
        oidx++;
        exp_cnt++;
      end
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    chk("stream_done", oidx, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t vecs [5];
    int first, last;

    vecs[0] = '{72'hFF8040201008040201, 16'h55AA, 24'h3F3807, 24'h6AC7AD};
    vecs[1] = '{72'h0,                  16'h0F0F, 24'h000000, 24'h0F000F};
    vecs[2] = '{72'hFFFFFFFFFFFFFFFFFF, 16'h0000, 24'hFFFFFF, 24'hFFFFFF};
    vecs[3] = '{72'h000000001000000000, 16'h0000, 24'h001000, 24'h001000};
    vecs[4] = '{72'h090807060504030201, 16'h0000, 24'h060700, 24'h060700};

    // Reset then idle
    rst = 1'b1; in_valid = 1'b0; in_shares = '0; fresh_m = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_shares", {8'h0, out_shares}, 32'h0);
    chk("rst_item_cnt", {16'h0, item_cnt}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;
    tick();

    // Single-word vectors: 2-cycle latency, value, count, clear on drain
    for (int i = 0; i < 5; i++) begin
      logic [23:0] exp;
`ifdef SHARE_REFRESH_EN
      exp = vecs[i].exp_ref;
`else
      exp = vecs[i].exp_plain;
`endif
      in_valid = 1'b1; in_shares = vecs[i].sh; fresh_m = vecs[i].fm; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_shares = '0; fresh_m = ~vecs[i].fm;
      chk("vec_lat1_valid", {31'h0, out_valid}, 32'h0);
      tick();
      chk("vec_lat2_valid", {31'h0, out_valid}, 32'h1);
      chk("vec_shares", {8'h0, out_shares}, {8'h0, exp});
      chk("vec_xor", {24'h0, xor3(out_shares)}, {24'h0, xor9(vecs[i].sh)});
      tick();
      exp_cnt++;
      chk("vec_item_cnt", {16'h0, item_cnt}, exp_cnt);
      chk("vec_drain_valid", {31'h0, out_valid}, 32'h0);
      chk("vec_drain_clear", {8'h0, out_shares}, 32'h0);
    end
    fresh_m = '0;

    // Back-to-back burst of 16 random words
    for (int i = 0; i < 16; i++)
      words[i] = {$urandom(), $urandom(), 8'($urandom())};
    run_stream(16, 1000, 0, first, last);
    chk("burst_contiguous", last - first, 15);
    chk("burst_item_cnt", {16'h0, item_cnt}, exp_cnt);

    // Backpressure mid-burst, order tracked by distinct per-word XOR
    for (int i = 0; i < 10; i++) words[i] = {64'h0, 8'(i + 1)};
    run_stream(10, 4, 5, first, last);
    chk("bp_item_cnt", {16'h0, item_cnt}, exp_cnt);

    // Reset with both stages full; held words must vanish
    words[0] = {64'h0, 8'h5A};
    words[1] = {64'h0, 8'hA5};
    out_ready = 1'b0;
    in_valid = 1'b1; in_shares = words[0];
    tick();
    in_shares = words[1];
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    rst = 1'b1; in_valid = 1'b1; in_shares = 72'h123456789ABCDEF012;
    tick();
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_item_cnt", {16'h0, item_cnt}, 32'h0);
    chk("midrst_out_shares", {8'h0, out_shares}, 32'h0);
    rst = 1'b0; in_valid = 1'b0; in_shares = '0; out_ready = 1'b1;
    #1;
    chk("postrst_in_ready", {31'h0, in_ready}, 32'h1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("postrst_no_ghost", {31'h0, out_valid}, 32'h0);
    end
    chk("postrst_item_cnt", {16'h0, item_cnt}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
